key_event_gen: RTL and testbench



---
 rtl/key_event_gen.sv | 159 +++++++++++++++
 tb/tb_key_event_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_gen.sv
// Push-button front-end: per-key synchroniser, debouncer and hold FSM producing
// a debounced level plus single-cycle press, release, long-press and auto-repeat pulses.
module key_event_gen #(
   parameter int NKEYS           = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 12500000
) (
   input  logic                 clk_50mhz,
   input  logic                 reset,
   input  logic [NKEYS-1:0]     key_n,
   output logic [NKEYS-1:0]     key_level,
   output logic [NKEYS-1:0]     key_press,
   output logic [NKEYS-1:0]     key_release,
   output logic [NKEYS-1:0]     key_long,
   output logic [NKEYS-1:0]     key_repeat,
   output logic [2*NKEYS-1:0]   hold_state
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } hold_state_t;

   for (genvar k = 0; k < NKEYS; k++) begin : g_key
      logic              sync1;
      logic              sync2;
      logic              pressed_s;
      logic              level;
      logic [DB_W-1:0]   db_cnt;
      logic              differ;
      logic              db_done;
      logic              rise;
      logic              fall;

      hold_state_t       state;
      hold_state_t       state_nx;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_cnt_nx;
      logic [REP_W-1:0]  rep_cnt;
      logic [REP_W-1:0]  rep_cnt_nx;

      logic press_q, release_q, long_q, repeat_q;
      logic press_nx, release_nx, long_nx, repeat_nx;

      assign pressed_s = ~sync2;
      assign differ    = (pressed_s != level);
      assign db_done   = differ && (db_cnt == DB_LAST);
      assign rise      = db_done && pressed_s;
      assign fall      = db_done && !pressed_s;

      // Synchroniser presets to "released" so a key held through reset is re-debounced.
      always_ff @(posedge clk_50mhz) begin
         if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            db_cnt <= '0;
            level  <= 1'b0;
         end else begin
            sync1 <= key_n[k];
            sync2 <= sync1;
            if (!differ) begin
               db_cnt <= '0;
            end else if (db_done) begin
               level  <= pressed_s;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end
      end

      // A release debouncing on the same edge wins over any long/repeat pulse.
      always_comb begin
         state_nx    = state;
         hold_cnt_nx = hold_cnt;
         rep_cnt_nx  = rep_cnt;
         press_nx    = 1'b0;
         release_nx  = 1'b0;
         long_nx     = 1'b0;
         repeat_nx   = 1'b0;
         if (fall) begin
            state_nx    = ST_IDLE;
            hold_cnt_nx = '0;
            rep_cnt_nx  = '0;
            release_nx  = 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rise) begin
                     state_nx    = ST_HELD;
                     hold_cnt_nx = '0;
                     press_nx    = 1'b1;
                     repeat_nx   = 1'b1;
                  end
               end
               ST_HELD: begin
                  if (hold_cnt == HOLD_LAST) begin
                     state_nx   = ST_REPEAT;
                     rep_cnt_nx = '0;
                     long_nx    = 1'b1;
                     repeat_nx  = 1'b1;
                  end else begin
                     hold_cnt_nx = hold_cnt + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt == REP_LAST) begin
                     rep_cnt_nx = '0;
                     repeat_nx  = 1'b1;
                  end else begin
                     rep_cnt_nx = rep_cnt + 1'b1;
                  end
               end
               default: begin
                  state_nx = ST_IDLE;
               end
            endcase
         end
      end

      always_ff @(posedge clk_50mhz) begin
         if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state     <= state_nx;
            hold_cnt  <= hold_cnt_nx;
            rep_cnt   <= rep_cnt_nx;
            press_q   <= press_nx;
            release_q <= release_nx;
            long_q    <= long_nx;
            repeat_q  <= repeat_nx;
         end
      end

      assign key_level[k]          = level;
      assign key_press[k]          = press_q;
      assign key_release[k]        = release_q;
      assign key_long[k]           = long_q;
      assign key_repeat[k]         = repeat_q;
      assign hold_state[2*k +: 2]  = state;
   end

endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: randomized and scenario key waveforms, a window-based
// reference model feeding an expected queue, and a per-cycle output monitor.
module tb_key_event_gen;

   localparam int NK   = 3;
   localparam int DB   = 4;
   localparam int LG   = 20;
   localparam int RP   = 5;
   localparam int W    = 5 * NK;
   localparam int MAXC = 8192;

   logic              clk_50mhz = 1'b0;
   logic              reset     = 1'b1;
   logic [NK-1:0]     key_n     = '1;
   logic [NK-1:0]     key_level;
   logic [NK-1:0]     key_press;
   logic [NK-1:0]     key_release;
   logic [NK-1:0]     key_long;
   logic [NK-1:0]     key_repeat;
   logic [2*NK-1:0]   hold_state;

   always #10 clk_50mhz = ~clk_50mhz;

   key_event_gen #(
      .NKEYS           (NK),
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LG),
      .REPEAT_CYCLES   (RP)
   ) dut (
      .clk_50mhz   (clk_50mhz),
      .reset       (reset),
      .key_n       (key_n),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_repeat  (key_repeat),
      .hold_state  (hold_state)
   );

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: pressed value per cycle, level flips once the last DB
   // cycles all disagree with it; pulses follow from time since the press.
   bit m_ps_log [NK][MAXC];
   bit m_level  [NK];
   bit m_raw    [NK];
   int m_press  [NK];

   task automatic model_edge(input bit rst, input logic [NK-1:0] kn);
      logic [NK-1:0] lv, pr, rl, lo, re;
      bit flip;
      bit new_lv;
      int age;
      lv = '0; pr = '0; rl = '0; lo = '0; re = '0;
      cyc++;
      for (int k = 0; k < NK; k++) begin
         if (rst) begin
            m_level[k]       = 1'b0;
            m_raw[k]         = 1'b1;
            m_press[k]       = 0;
            m_ps_log[k][cyc] = 1'b0;
         end else begin
            flip = (cyc > DB);
            for (int i = 1; i <= DB; i++)
               if (flip && m_ps_log[k][cyc-i] == m_level[k]) flip = 1'b0;
            new_lv = flip ? ~m_level[k] : m_level[k];
            if (new_lv && !m_level[k]) begin
               pr[k] = 1'b1;
               re[k] = 1'b1;
               m_press[k] = cyc;
            end else if (!new_lv && m_level[k]) begin
               rl[k] = 1'b1;
            end else if (new_lv) begin
               age = cyc - m_press[k];
               if (age == LG) begin
                  lo[k] = 1'b1;
                  re[k] = 1'b1;
               end else if (age > LG && ((age - LG) % RP) == 0) begin
                  re[k] = 1'b1;
               end
            end
            m_level[k]       = new_lv;
            m_ps_log[k][cyc] = ~m_raw[k];
            m_raw[k]         = kn[k];
         end
         lv[k] = m_level[k];
      end
      exp_q.push_back({lv, pr, rl, lo, re});
   endtask

   task automatic step(input bit rst, input logic [NK-1:0] kn);
      reset = rst;
      key_n = kn;
      @(posedge clk_50mhz);
      model_edge(rst, kn);
      #1;
   endtask

   task automatic hold(input bit rst, input logic [NK-1:0] kn, input int n);
      for (int i = 0; i < n; i++) step(rst, kn);
   endtask

   always @(negedge clk_50mhz) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] got_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         got_v = {key_level, key_press, key_release, key_long, key_repeat};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs cyc=%0d got=%h exp=%h (level,press,release,long,repeat)",
                     cyc, got_v, exp_v);
         end
         for (int k = 0; k < NK; k++) begin
            if (!exp_v[4*NK + k]) begin
               n_cmp++;
               if (hold_state[2*k +: 2] !== 2'b00) begin
                  n_bad++;
                  $display("FAIL idle_state key=%0d cyc=%0d got=%b exp=00",
                           k, cyc, hold_state[2*k +: 2]);
               end
            end
         end
      end
   end

   initial begin
      int rem [NK];
      logic [NK-1:0] cur;
      int lens [5];

      // reset, then quiet
      hold(1'b1, 3'b111, 3);
      hold(1'b0, 3'b111, 50);

      // clean press on key 1
      hold(1'b0, 3'b111, 10);
      hold(1'b0, 3'b101, 30);
      hold(1'b0, 3'b111, 30);

      // bounce on key 0, then stable low
      for (int i = 0; i < 5; i++) begin
         hold(1'b0, 3'b110, 3);
         hold(1'b0, 3'b111, 3);
      end
      hold(1'b0, 3'b110, 12);
      hold(1'b0, 3'b111, 12);

      // long press and repeats on key 2
      hold(1'b0, 3'b011, 50);
      hold(1'b0, 3'b111, 12);

      // keys 0 and 2 together
      hold(1'b0, 3'b010, 45);
      hold(1'b0, 3'b111, 12);

      // reset mid-repeat with key 2 still held
      hold(1'b0, 3'b011, 33);
      hold(1'b1, 3'b011, 2);
      hold(1'b0, 3'b011, 20);
      hold(1'b0, 3'b111, 12);

      // release racing long and repeat pulses on key 1
      lens[0] = LG - 1; lens[1] = LG; lens[2] = LG + 1; lens[3] = LG + RP; lens[4] = LG + RP + 1;
      for (int i = 0; i < 5; i++) begin
         hold(1'b0, 3'b101, lens[i]);
         hold(1'b0, 3'b111, 12);
      end

      // random per-key segments with occasional reset
      cur = '1;
      for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 20);
      for (int c = 0; c < 2800; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (rem[k] == 0) begin
               cur[k] = ~cur[k];
               rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5)
                                                    : $urandom_range(5, 45);
            end
            rem[k]--;
         end
         step(($urandom_range(0, 399) == 0), cur);
      end
      hold(1'b0, 3'b111, 12);

      @(negedge clk_50mhz);
      @(negedge clk_50mhz);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
